// File: rtl/hazard_forward_unit_if.sv
// Bus between the ID/EX pipeline registers and the hazard/forwarding unit.
// slave  : the hazard_forward_unit side (takes pipeline indices, drives selects/stalls)
// master : the pipeline side (drives indices and control, observes selects/stalls)
// Signals:
//   ex_rs1_i/ex_rs2_i         EX-stage source indices
//   fwd_rd_i/fwd_regwrite_i   per-producer-stage destination and RegWrite (slice i = stage i)
//   id_rs*_i/id_rs*_use_i     ID-stage sources and their use flags
//   id_mc_i                   ID instruction is a multi-cycle op
//   ex_memread_i/ex_rd_i      EX load flag and destination
//   mc_start_i/mc_rd_i        multi-cycle issue and its destination
//   cnt_clr_i                 clear for the stall counter
//   forward_a_o/forward_b_o   ALU operand selects
//   stall_o                   pipeline hold / bubble request
//   mc_busy_o/mc_done_o/mc_err_o  multi-cycle unit status
//   stall_cnt_o               saturating stall-cycle count
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_STAGES = 2,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic [REG_ADDR_W-1:0]            ex_rs1_i;
    logic [REG_ADDR_W-1:0]            ex_rs2_i;
    logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_rd_i;
    logic [FWD_STAGES-1:0]            fwd_regwrite_i;
    logic [REG_ADDR_W-1:0]            id_rs1_i;
    logic [REG_ADDR_W-1:0]            id_rs2_i;
    logic                             id_rs1_use_i;
    logic                             id_rs2_use_i;
    logic                             id_mc_i;
    logic                             ex_memread_i;
    logic [REG_ADDR_W-1:0]            ex_rd_i;
    logic                             mc_start_i;
    logic [REG_ADDR_W-1:0]            mc_rd_i;
    logic                             cnt_clr_i;
    logic [SEL_W-1:0]                 forward_a_o;
    logic [SEL_W-1:0]                 forward_b_o;
    logic                             stall_o;
    logic                             mc_busy_o;
    logic                             mc_done_o;
    logic                             mc_err_o;
    logic [CNT_W-1:0]                 stall_cnt_o;

    modport slave (
        input  ex_rs1_i, ex_rs2_i, fwd_rd_i, fwd_regwrite_i,
        input  id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i, id_mc_i,
        input  ex_memread_i, ex_rd_i, mc_start_i, mc_rd_i, cnt_clr_i,
        output forward_a_o, forward_b_o, stall_o,
        output mc_busy_o, mc_done_o, mc_err_o, stall_cnt_o
    );

    modport master (
        output ex_rs1_i, ex_rs2_i, fwd_rd_i, fwd_regwrite_i,
        output id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i, id_mc_i,
        output ex_memread_i, ex_rd_i, mc_start_i, mc_rd_i, cnt_clr_i,
        input  forward_a_o, forward_b_o, stall_o,
        input  mc_busy_o, mc_done_o, mc_err_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use stall detection and multi-cycle (mul/div)
// occupancy tracking for the EX stage, plus a saturating stall-cycle counter.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-low reset
//   hfu    hazard_forward_unit_if.slave carrying all pipeline-side signals
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | multi-cycle unit free, mc_start_i accepted
// ST_BUSY | op in flight; cnt_q counts remaining cycles down to 0
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_STAGES = 2,
    parameter int MC_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hazard_forward_unit_if.slave  hfu
);
    localparam int SEL_W    = $clog2(FWD_STAGES + 1);
    localparam int MC_CNT_W = $clog2(MC_LAT) + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
    logic                  mc_done_q, mc_done_d;
    logic                  mc_err_q, mc_err_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic [SEL_W-1:0]      fwd_a, fwd_b;
    logic [REG_ADDR_W-1:0] stage_rd;
    logic                  load_use_stall;
    logic                  mc_raw;
    logic                  mc_stall;
    logic                  stall;

    // Walk from the oldest stage to the youngest so the youngest match
    // overwrites anything older.
    always_comb begin
        fwd_a    = '0;
        fwd_b    = '0;
        stage_rd = '0;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            stage_rd = hfu.fwd_rd_i[i*REG_ADDR_W +: REG_ADDR_W];
            if (hfu.fwd_regwrite_i[i] && (stage_rd != '0)) begin
                if (stage_rd == hfu.ex_rs1_i) fwd_a = SEL_W'(FWD_STAGES - i);
                if (stage_rd == hfu.ex_rs2_i) fwd_b = SEL_W'(FWD_STAGES - i);
            end
        end
    end

    always_comb begin
        load_use_stall = hfu.ex_memread_i && (hfu.ex_rd_i != '0) &&
                         ((hfu.id_rs1_use_i && (hfu.id_rs1_i == hfu.ex_rd_i)) ||
                          (hfu.id_rs2_use_i && (hfu.id_rs2_i == hfu.ex_rd_i)));
        mc_raw         = (pend_rd_q != '0) &&
                         ((hfu.id_rs1_use_i && (hfu.id_rs1_i == pend_rd_q)) ||
                          (hfu.id_rs2_use_i && (hfu.id_rs2_i == pend_rd_q)));
        // The unit only holds one op, so any ID multi-cycle op must wait.
        mc_stall       = (state_q == ST_BUSY) && (mc_raw || hfu.id_mc_i);
        stall          = load_use_stall || mc_stall;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_rd_d = pend_rd_q;
        mc_done_d = 1'b0;
        mc_err_d  = mc_err_q;
        case (state_q)
            ST_IDLE: begin
                if (hfu.mc_start_i) begin
                    state_d   = ST_BUSY;
                    cnt_d     = MC_CNT_W'(MC_LAT - 1);
                    pend_rd_d = hfu.mc_rd_i;
                end
            end
            ST_BUSY: begin
                // A second issue is dropped but remembered as an error.
                if (hfu.mc_start_i) mc_err_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    mc_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (hfu.cnt_clr_i) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_rd_q   <= '0;
            mc_done_q   <= 1'b0;
            mc_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_rd_q   <= pend_rd_d;
            mc_done_q   <= mc_done_d;
            mc_err_q    <= mc_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hfu.forward_a_o = fwd_a;
    assign hfu.forward_b_o = fwd_b;
    assign hfu.stall_o     = stall;
    assign hfu.mc_busy_o   = (state_q == ST_BUSY);
    assign hfu.mc_done_o   = mc_done_q;
    assign hfu.mc_err_o    = mc_err_q;
    assign hfu.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios followed by random
// stimulus, all compared against a cycle-level reference model.
module tb_hazard_forward_unit;
    localparam int RW      = 5;
    localparam int NSTG    = 2;
    localparam int LAT     = 4;
    localparam int CW      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.REG_ADDR_W(RW), .FWD_STAGES(NSTG), .CNT_W(CW)) bus ();

    hazard_forward_unit #(
        .REG_ADDR_W (RW),
        .FWD_STAGES (NSTG),
        .MC_LAT     (LAT),
        .CNT_W      (CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .hfu   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_rem;      // busy cycles still to run, 0 = free
    int          m_pend;
    int          m_cnt;
    logic        m_done;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input int rs);
        for (int i = 0; i < NSTG; i++) begin
            int rd = int'(bus.fwd_rd_i[i*RW +: RW]);
            if (bus.fwd_regwrite_i[i] && rd != 0 && rd == rs) return NSTG - i;
        end
        return 0;
    endfunction

    function automatic logic ref_reads(input int r);
        return (bus.id_rs1_use_i && int'(bus.id_rs1_i) == r) ||
               (bus.id_rs2_use_i && int'(bus.id_rs2_i) == r);
    endfunction

    function automatic logic ref_stall();
        logic lu, mc;
        lu = bus.ex_memread_i && bus.ex_rd_i != 0 && ref_reads(int'(bus.ex_rd_i));
        mc = (m_rem > 0) && ((m_pend != 0 && ref_reads(m_pend)) || bus.id_mc_i);
        return lu || mc;
    endfunction

    task automatic model_reset();
        m_rem  = 0;
        m_pend = 0;
        m_cnt  = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        logic st;
        st = ref_stall();
        if (bus.cnt_clr_i) m_cnt = 0;
        else if (st && m_cnt < CNT_MAX) m_cnt++;
        m_done = 1'b0;
        if (m_rem > 0) begin
            if (bus.mc_start_i) m_err = 1'b1;
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else if (bus.mc_start_i) begin
            m_rem  = LAT;
            m_pend = int'(bus.mc_rd_i);
        end
    endtask

    task automatic check_model();
        check("fwd_a", 32'(bus.forward_a_o), 32'(ref_fwd(int'(bus.ex_rs1_i))));
        check("fwd_b", 32'(bus.forward_b_o), 32'(ref_fwd(int'(bus.ex_rs2_i))));
        check("stall", 32'(bus.stall_o), 32'(ref_stall()));
        check("busy", 32'(bus.mc_busy_o), 32'(m_rem > 0));
        check("done", 32'(bus.mc_done_o), 32'(m_done));
        check("err", 32'(bus.mc_err_o), 32'(m_err));
        check("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_cnt));
    endtask

    // inputs are already applied; compare mid-cycle, then advance one edge
    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        bus.ex_rs1_i       = '0;
        bus.ex_rs2_i       = '0;
        bus.fwd_rd_i       = '0;
        bus.fwd_regwrite_i = '0;
        bus.id_rs1_i       = '0;
        bus.id_rs2_i       = '0;
        bus.id_rs1_use_i   = 1'b0;
        bus.id_rs2_use_i   = 1'b0;
        bus.id_mc_i        = 1'b0;
        bus.ex_memread_i   = 1'b0;
        bus.ex_rd_i        = '0;
        bus.mc_start_i     = 1'b0;
        bus.mc_rd_i        = '0;
        bus.cnt_clr_i      = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_busy", 32'(bus.mc_busy_o), 32'd0);
        check("rst_done", 32'(bus.mc_done_o), 32'd0);
        check("rst_err", 32'(bus.mc_err_o), 32'd0);
        check("rst_cnt", 32'(bus.stall_cnt_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        bus.ex_rs1_i       = RW'($urandom_range(0, 3));
        bus.ex_rs2_i       = RW'($urandom_range(0, 3));
        bus.fwd_rd_i       = {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))};
        bus.fwd_regwrite_i = NSTG'($urandom_range(0, 3));
        bus.id_rs1_i       = RW'($urandom_range(0, 3));
        bus.id_rs2_i       = RW'($urandom_range(0, 3));
        bus.id_rs1_use_i   = 1'($urandom_range(0, 1));
        bus.id_rs2_use_i   = 1'($urandom_range(0, 1));
        bus.id_mc_i        = ($urandom_range(0, 3) == 0);
        bus.ex_memread_i   = ($urandom_range(0, 2) == 0);
        bus.ex_rd_i        = RW'($urandom_range(0, 3));
        bus.mc_start_i     = ($urandom_range(0, 4) == 0);
        bus.mc_rd_i        = RW'($urandom_range(0, 3));
        bus.cnt_clr_i      = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #3;
        apply_reset();

        // forwarding priority
        bus.ex_rs1_i = 5'd3;
        bus.ex_rs2_i = 5'd4;
        bus.fwd_rd_i = {5'd3, 5'd3};
        bus.fwd_regwrite_i = 2'b11;
        #1;
        check("fwd_a_stage0", 32'(bus.forward_a_o), 32'd2);
        check("fwd_b_nomatch", 32'(bus.forward_b_o), 32'd0);
        tick();
        bus.fwd_regwrite_i = 2'b10;
        bus.ex_rs2_i = 5'd3;
        #1;
        check("fwd_a_stage1", 32'(bus.forward_a_o), 32'd1);
        check("fwd_b_stage1", 32'(bus.forward_b_o), 32'd1);
        tick();
        bus.fwd_rd_i = '0;
        bus.fwd_regwrite_i = 2'b11;
        bus.ex_rs1_i = 5'd0;
        #1;
        check("fwd_a_rd0", 32'(bus.forward_a_o), 32'd0);
        tick();

        // load-use
        clear_inputs();
        bus.ex_memread_i = 1'b1;
        bus.ex_rd_i = 5'd5;
        bus.id_rs2_i = 5'd5;
        bus.id_rs2_use_i = 1'b1;
        #1;
        check("lu_stall", 32'(bus.stall_o), 32'd1);
        check("lu_cnt0", 32'(bus.stall_cnt_o), 32'd0);
        tick();
        check("lu_cnt1", 32'(bus.stall_cnt_o), 32'd1);
        bus.id_rs2_use_i = 1'b0;
        #1;
        check("lu_nouse", 32'(bus.stall_o), 32'd0);
        tick();

        // multi-cycle RAW
        clear_inputs();
        bus.mc_start_i = 1'b1;
        bus.mc_rd_i = 5'd7;
        bus.id_rs1_i = 5'd7;
        bus.id_rs1_use_i = 1'b1;
        tick();
        bus.mc_start_i = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            #1;
            check("mc_busy", 32'(bus.mc_busy_o), 32'd1);
            check("mc_raw_stall", 32'(bus.stall_o), 32'd1);
            check("mc_no_done", 32'(bus.mc_done_o), 32'd0);
            tick();
        end
        #1;
        check("mc_done", 32'(bus.mc_done_o), 32'd1);
        check("mc_idle", 32'(bus.mc_busy_o), 32'd0);
        check("mc_release", 32'(bus.stall_o), 32'd0);
        tick();
        check("mc_done_pulse", 32'(bus.mc_done_o), 32'd0);

        // structural stall and start while busy
        clear_inputs();
        bus.mc_start_i = 1'b1;
        bus.mc_rd_i = 5'd9;
        tick();
        bus.id_mc_i = 1'b1;
        bus.id_rs1_i = 5'd1;
        bus.id_rs1_use_i = 1'b1;
        #1;
        check("struct_stall", 32'(bus.stall_o), 32'd1);
        tick();
        bus.mc_start_i = 1'b0;
        check("err_set", 32'(bus.mc_err_o), 32'd1);
        for (int k = 0; k < LAT - 1; k++) tick();
        check("err_busy_len", 32'(bus.mc_busy_o), 32'd0);
        check("err_done", 32'(bus.mc_done_o), 32'd1);
        tick();
        check("err_sticky", 32'(bus.mc_err_o), 32'd1);

        // saturation and clear priority
        clear_inputs();
        bus.cnt_clr_i = 1'b1;
        tick();
        bus.cnt_clr_i = 1'b0;
        bus.ex_memread_i = 1'b1;
        bus.ex_rd_i = 5'd5;
        bus.id_rs2_i = 5'd5;
        bus.id_rs2_use_i = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("cnt_sat", 32'(bus.stall_cnt_o), 32'd7);
        bus.cnt_clr_i = 1'b1;
        tick();
        check("cnt_clr", 32'(bus.stall_cnt_o), 32'd0);

        // reset in the middle of BUSY
        clear_inputs();
        bus.mc_start_i = 1'b1;
        bus.mc_rd_i = 5'd7;
        tick();
        bus.id_rs1_i = 5'd7;
        bus.id_rs1_use_i = 1'b1;
        tick();
        bus.mc_start_i = 1'b0;
        #2;
        check("pre_rst_err", 32'(bus.mc_err_o), 32'd1);
        apply_reset();
        clear_inputs();
        for (int k = 0; k < LAT + 2; k++) begin
            #1;
            check("rst_no_done", 32'(bus.mc_done_o), 32'd0);
            tick();
        end

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) apply_reset();
            rand_inputs();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
